loadstore_unit: RTL and testbench

LOADSTORE_UNIT -- requirements
Module: loadstore_unit

---
 rtl/loadstore_unit.sv | 143 ++++++++++++++
 tb/tb_loadstore_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/loadstore_unit.sv
// Load/store unit between a pipeline request port and a single-port word memory.
// Sub-word stores are done as read-modify-write; all memory-side outputs are registered.
module loadstore_unit #(
  parameter int MEM_WORDS = 128,
  parameter int MEM_AW    = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              memread,
  output logic              memwrite,
  output logic [MEM_AW-1:0] addr,
  output logic [31:0]       write_data,
  input  logic [31:0]       read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [31:0] MEM_WORDS_W = MEM_WORDS;

  state_t      state, state_next;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic        accept;
  logic        misaligned, out_of_range, bad_funct3, fault;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && (state == IDLE);

  // Fault classification of the incoming request; a faulted access never touches memory.
  always_comb begin
    misaligned = 1'b0;
    bad_funct3 = 1'b0;
    case (req_funct3)
      3'b000:  misaligned = 1'b0;
      3'b100:  bad_funct3 = req_write;
      3'b001:  misaligned = req_addr[0];
      3'b101: begin
        misaligned = req_addr[0];
        bad_funct3 = req_write;
      end
      3'b010:  misaligned = |req_addr[1:0];
      default: bad_funct3 = 1'b1;
    endcase
    out_of_range = (32'(req_addr[MEM_AW+1:2]) >= MEM_WORDS_W) ||
                   (req_addr[31:MEM_AW+2] != '0);
    fault = misaligned | out_of_range | bad_funct3;
  end

  always_comb begin
    load_byte = read_data[{off_q, 3'b000} +: 8];
    load_half = off_q[1] ? read_data[31:16] : read_data[15:0];
    case (funct3_q[1:0])
      2'b00:   load_val = {{24{load_byte[7] & ~funct3_q[2]}}, load_byte};
      2'b01:   load_val = {{16{load_half[15] & ~funct3_q[2]}}, load_half};
      default: load_val = read_data;
    endcase
  end

  // Lanes outside the stored byte/halfword keep the value just read.
  always_comb begin
    merged = read_data;
    if (funct3_q[1:0] == 2'b00)
      merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (fault)
            state_next = RESP;
          else if (req_write && req_funct3 == 3'b010)
            state_next = WRITE;
          else
            state_next = READ;
        end
      end
      READ:    state_next = write_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  // Memory strobes are decoded from the next state and registered so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memread    <= 1'b0;
      memwrite   <= 1'b0;
      addr       <= '0;
      write_data <= '0;
      write_q    <= 1'b0;
      funct3_q   <= '0;
      off_q      <= '0;
      wdata_q    <= '0;
      rsp_rdata  <= '0;
      rsp_fault  <= 1'b0;
    end else begin
      memread  <= (state_next == READ);
      memwrite <= (state_next == WRITE);
      if (accept) begin
        write_q    <= req_write;
        funct3_q   <= req_funct3;
        off_q      <= req_addr[1:0];
        wdata_q    <= req_wdata[15:0];
        addr       <= req_addr[MEM_AW+1:2];
        write_data <= req_wdata;
      end
      if (state == READ && write_q)
        write_data <= merged;
      if (state_next == RESP && state != RESP) begin
        rsp_fault <= (state == IDLE);
        rsp_rdata <= (state == READ && !write_q) ? load_val : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_loadstore_unit.sv
// Scoreboard bench for loadstore_unit: a byte-level reference model predicts fault,
// load data and latency per request; a negedge monitor compares each response in order.
module tb_loadstore_unit;

  localparam int MEM_WORDS = 128;
  localparam int MEM_AW    = 9;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;
  logic              memread;
  logic              memwrite;
  logic [MEM_AW-1:0] addr;
  logic [31:0]       write_data;
  logic [31:0]       read_data;

  typedef struct {
    string       name;
    logic        fault;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  int checks = 0, errors = 0, cycle = 0;
  int act_reads = 0, act_writes = 0, exp_reads = 0, exp_writes = 0;

  loadstore_unit #(.MEM_WORDS(MEM_WORDS), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .memread(memread), .memwrite(memwrite), .addr(addr),
    .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  assign read_data = (int'(addr) < MEM_WORDS) ? mem[addr] : 32'h0;
  always @(posedge clk) if (memwrite && int'(addr) < MEM_WORDS) mem[addr] <= write_data;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed view of memory, computed from size/alignment rules.
  task automatic model(input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic f, output logic [31:0] rd,
                       output int lat);
    int size, lane;
    bit legal;
    longint v, word;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = w ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    f     = !legal || (a % size != 0) || ((a >> 2) >= MEM_WORDS);
    rd    = 32'h0;
    if (f) begin
      lat = 1;
    end else if (!w) begin
      word = longint'(ref_mem[a >> 2]);
      v = (word >> (8 * (a % 4))) & ((64'd1 << (8 * size)) - 1);
      if (size < 4 && !f3[2] && v >= (64'd1 << (8 * size - 1)))
        v = v - (64'd1 << (8 * size));
      rd  = v[31:0];
      lat = 2;
      exp_reads++;
    end else begin
      for (int i = 0; i < size; i++) begin
        lane = int'(a % 4) + i;
        ref_mem[a >> 2][8 * lane +: 8] = wd[8 * i +: 8];
      end
      lat = (size == 4) ? 2 : 3;
      exp_writes++;
      if (size < 4) exp_reads++;
    end
  endtask

  // Issues one request from a negedge, waits (bounded) for acceptance, pushes the expectation.
  task automatic applyStimulus(input string name, input bit w, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input bit hold, output int acc);
    exp_t e;
    int n;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = cycle;
    if (!req_ready) begin
      checkOutput({name, "_accept_timeout"}, 32'(req_ready), 32'h1);
      req_valid = 1'b0;
    end else begin
      e.name = name;
      e.acc  = cycle;
      model(w, f3, a, wd, e.fault, e.rdata, e.lat);
      exp_q.push_back(e);
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 32'(exp_q.size()), 32'h0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (memwrite) act_writes++;
      if (memread) act_reads++;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rsp actual=1 expected=0");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput({e.name, "_fault"}, 32'(rsp_fault), 32'(e.fault));
          checkOutput({e.name, "_rdata"}, rsp_rdata, e.rdata);
          checkOutput({e.name, "_latency"}, 32'(cycle - e.acc), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    int acc;
    int accs[4];
    int rsp_seen;
    logic [31:0] w0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_funct3 = 3'b000;
    req_addr = '0;
    req_wdata = '0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      w0 = $urandom;
      mem[i] = w0;
      ref_mem[i] = w0;
    end
    #3;
    checkOutput("rst_req_ready", 32'(req_ready), 32'h1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_rsp_fault", 32'(rsp_fault), 32'h0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_mem_strobes", {30'h0, memread, memwrite}, 32'h0);
    checkOutput("rst_addr", 32'(addr), 32'h0);
    checkOutput("rst_write_data", write_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, acc);
    applyStimulus("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, acc);
    waitDrain();
    checkOutput("sw_mem4", mem[4], 32'hDEADBEEF);

    applyStimulus("sb_11", 1'b1, 3'b000, 32'h11, 32'h000000A5, 1'b0, acc);
    applyStimulus("lb_11", 1'b0, 3'b000, 32'h11, 32'h0, 1'b0, acc);
    applyStimulus("lbu_11", 1'b0, 3'b100, 32'h11, 32'h0, 1'b0, acc);
    waitDrain();
    checkOutput("sb_mem4", mem[4], 32'hDEADA5EF);

    applyStimulus("sw_08", 1'b1, 3'b010, 32'h08, 32'h80017FFF, 1'b0, acc);
    applyStimulus("lh_0a", 1'b0, 3'b001, 32'h0A, 32'h0, 1'b0, acc);
    applyStimulus("lh_08", 1'b0, 3'b001, 32'h08, 32'h0, 1'b0, acc);
    applyStimulus("lhu_0a", 1'b0, 3'b101, 32'h0A, 32'h0, 1'b0, acc);
    waitDrain();

    applyStimulus("f_lw_13", 1'b0, 3'b010, 32'h13, 32'h0, 1'b0, acc);
    applyStimulus("f_sh_01", 1'b1, 3'b001, 32'h01, 32'h1234, 1'b0, acc);
    applyStimulus("f_sw_200", 1'b1, 3'b010, 32'h200, 32'h55AA55AA, 1'b0, acc);
    applyStimulus("f_sbu_04", 1'b1, 3'b100, 32'h04, 32'h77, 1'b0, acc);
    waitDrain();

    for (int i = 0; i < 4; i++) begin
      applyStimulus($sformatf("b2b_%0d", i), 1'b0, 3'b010, 32'(4 * i), 32'h0, i < 3, acc);
      accs[i] = acc;
    end
    waitDrain();
    for (int i = 1; i < 4; i++)
      checkOutput($sformatf("b2b_spacing_%0d", i), 32'(accs[i] - accs[i-1]), 32'd3);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, MEM_WORDS * 4 + 15));
      applyStimulus($sformatf("rnd_%0d", i), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), a, $urandom, 1'b0, acc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    waitDrain();

    req_write  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h20;
    req_wdata  = 32'h12345678;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int n = 0; n < 5 && !memwrite; n++) @(negedge clk);
    checkOutput("rst_mid_write_seen", 32'(memwrite), 32'h1);
    exp_writes++;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_memwrite", 32'(memwrite), 32'h0);
    checkOutput("rst_mid_req_ready", 32'(req_ready), 32'h1);
    checkOutput("rst_mid_addr", 32'(addr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    checkOutput("rst_mid_no_rsp", 32'(rsp_seen), 32'h0);
    checkOutput("rst_mid_ready_after", 32'(req_ready), 32'h1);

    checkOutput("mem_read_count", 32'(act_reads), 32'(exp_reads));
    checkOutput("mem_write_count", 32'(act_writes), 32'(exp_writes));
    for (int i = 0; i < MEM_WORDS; i++)
      checkOutput($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
